// File: rtl/fnv_pkg.sv
// ============================================================================
// fnv_pkg -- shared state encoding, FNV-1a constants and digest byte select
// Revision 1.0
// ============================================================================
`default_nettype none

package fnv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ABSORB = 2'd1,
    ST_EMIT   = 2'd2
  } fnv_state_e;

  localparam logic [31:0] FNV_OFFSET_BASIS = 32'd2166136261;
  localparam logic [31:0] FNV_PRIME_32     = 32'd16777619;
  localparam int unsigned FNV_FIFO_DEPTH   = 4;

  // Index 0 selects the most significant octet of the digest.
  function automatic logic [7:0] digest_byte(input logic [31:0] h, input logic [1:0] idx);
    case (idx)
      2'd0:    return h[31:24];
      2'd1:    return h[23:16];
      2'd2:    return h[15:8];
      default: return h[7:0];
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/fnv_1a_step.sv
// ============================================================================
// fnv_1a_step -- one combinational FNV-1a round: (hash ^ octet) * PRIME mod 2^32
// Revision 1.0
// ============================================================================
`default_nettype none

module fnv_1a_step
  import fnv_pkg::*;
#(
  parameter logic [31:0] PRIME = FNV_PRIME_32
) (
  input  logic [31:0] hash_i,
  input  logic [7:0]  octet_i,
  output logic [31:0] hash_o
);

  logic [31:0] w_mix;

  assign w_mix  = hash_i ^ {24'h0, octet_i};
  assign hash_o = w_mix * PRIME;

endmodule

`default_nettype wire

// File: rtl/fnv_byte_feeder.sv
// ============================================================================
// fnv_byte_feeder -- buffers message octets, hashes them with FNV-1a and
// streams the 32-bit digest out MSB first. Revision 1.0
// ============================================================================
`default_nettype none

module fnv_byte_feeder
  import fnv_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = FNV_FIFO_DEPTH,
  parameter logic [31:0] OFFSET_BASIS = FNV_OFFSET_BASIS,
  parameter logic [31:0] FNV_PRIME    = FNV_PRIME_32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fnv_state_e       state_q, state_d;
  logic [31:0]      hash_q, hash_d;
  logic [1:0]       idx_q, idx_d;
  logic             last_seen_q, last_seen_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [8:0]       fifo_q [FIFO_DEPTH];

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [8:0]       w_head;
  logic [31:0]      w_step_hash;

  assign w_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign w_empty = (count_q == '0);
  assign w_head  = fifo_q[rd_ptr_q];

  // in_ready depends only on registered state, never on in_valid.
  assign in_ready = !w_full && !last_seen_q && (state_q != ST_EMIT);
  assign w_push   = in_valid && in_ready && !clear;
  assign busy     = (state_q != ST_IDLE) || !w_empty;

  fnv_1a_step #(
    .PRIME (FNV_PRIME)
  ) u_step (
    .hash_i  (hash_q),
    .octet_i (w_head[7:0]),
    .hash_o  (w_step_hash)
  );

  always_comb begin
    state_d     = state_q;
    hash_d      = hash_q;
    idx_d       = idx_q;
    last_seen_d = last_seen_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    w_pop       = 1'b0;
    out_valid   = 1'b0;
    out_byte    = 8'h00;

    case (state_q)
      ST_IDLE: begin
        if (!w_empty) state_d = ST_ABSORB;
      end
      ST_ABSORB: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          hash_d = w_step_hash;
          if (w_head[8]) begin
            state_d = ST_EMIT;
            idx_d   = 2'd0;
          end
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_byte  = digest_byte(hash_q, idx_q);
        if (out_ready) begin
          if (idx_q == 2'd3) begin
            state_d     = ST_IDLE;
            hash_d      = OFFSET_BASIS;
            idx_d       = 2'd0;
            last_seen_d = 1'b0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (w_push && in_last) last_seen_d = 1'b1;

    if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flush wins over everything else happening this cycle.
    if (clear) begin
      state_d     = ST_IDLE;
      hash_d      = OFFSET_BASIS;
      idx_d       = 2'd0;
      last_seen_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hash_q      <= OFFSET_BASIS;
      idx_q       <= 2'd0;
      last_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      hash_q      <= hash_d;
      idx_q       <= idx_d;
      last_seen_q <= last_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) fifo_q[wr_ptr_q] <= {in_last, in_data};
  end

endmodule

`default_nettype wire

// File: tb/tb_fnv_byte_feeder.sv
// ============================================================================
// tb_fnv_byte_feeder -- directed and randomized checks of fnv_byte_feeder
// against an FNV-1a reference computed from the message contents. Revision 1.0
// ============================================================================
`default_nettype none

module tb_fnv_byte_feeder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] msg_q [$];
  bit         mark_last = 1'b1;

  always #5 clk = ~clk;

  fnv_byte_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference digest straight from the FNV-1a definition.
  function automatic logic [31:0] fnv_ref();
    logic [31:0] h;
    h = 32'h811C9DC5;
    foreach (msg_q[i]) h = (h ^ {24'h0, msg_q[i]}) * 32'h01000193;
    return h;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] d, input int k);
    return 8'(d >> (24 - 8 * k));
  endfunction

  task automatic set_foobar();
    msg_q = '{8'h66, 8'h6F, 8'h6F, 8'h62, 8'h61, 8'h72};
  endtask

  // Offers msg_q and drains the digest concurrently with random gaps.
  task automatic run_msg(input logic [31:0] exp, input int vprob, input int rprob, input string tag);
    int   sent = 0;
    int   got  = 0;
    int   cyc  = 0;
    logic acc;
    while (got < 4 && cyc < 2000) begin
      in_valid = (sent < msg_q.size()) && ($urandom_range(99) < vprob);
      in_data  = 8'h00;
      if (sent < msg_q.size()) in_data = msg_q[sent];
      in_last   = mark_last && (sent == msg_q.size() - 1);
      out_ready = ($urandom_range(99) < rprob);
      #1;
      acc = in_valid && in_ready;
      if (sent == msg_q.size()) chk({tag, " in_ready_after_last"}, 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        chk({tag, " all_in_before_out"}, sent, msg_q.size());
        chk({tag, " digest_byte"}, 32'(out_byte), 32'(exp_byte(exp, got)));
        got++;
      end
      tick();
      if (acc) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk({tag, " bytes_received"}, got, 32'd4);
    chk({tag, " busy_after"}, 32'(busy), 32'd0);
    chk({tag, " in_ready_after"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  task automatic send_all(input string tag);
    int sent = 0;
    int cyc  = 0;
    out_ready = 1'b0;
    while (sent < msg_q.size() && cyc < 200) begin
      in_valid = 1'b1;
      in_data  = msg_q[sent];
      in_last  = mark_last && (sent == msg_q.size() - 1);
      #1;
      if (in_ready) begin
        tick();
        sent++;
      end else begin
        tick();
      end
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, " sent"}, sent, msg_q.size());
  endtask

  task automatic wait_out(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk({tag, " out_valid_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_byte", 32'(out_byte), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst in_ready", 32'(in_ready), 32'd1);
    chk("post_rst busy", 32'(busy), 32'd0);

    // Single octet "a" at full rate.
    msg_q = '{8'h61};
    run_msg(32'hE40C292C, 100, 100, "a_full");

    // "foobar" at full rate; input blocked from last octet until digest done.
    set_foobar();
    run_msg(32'hBF9CF968, 100, 100, "foobar_full");

    // "foobar" with the consumer stalled for 10 cycles.
    set_foobar();
    send_all("stall");
    wait_out("stall");
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      #1;
      chk("stall out_valid", 32'(out_valid), 32'd1);
      chk("stall out_byte", 32'(out_byte), 32'hBF);
      chk("stall in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    msg_q.delete();
    run_msg(32'hBF9CF968, 0, 100, "stall_drain");

    // Clear after 3 octets, with a 4th octet offered on the clear cycle.
    msg_q     = '{8'h66, 8'h6F, 8'h6F};
    mark_last = 1'b0;
    send_all("clear_pre");
    mark_last = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h62;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    chk("clear busy", 32'(busy), 32'd0);
    chk("clear in_ready", 32'(in_ready), 32'd1);
    repeat (3) tick();
    chk("clear busy_later", 32'(busy), 32'd0);
    chk("clear out_valid_later", 32'(out_valid), 32'd0);
    msg_q = '{8'h61};
    run_msg(32'hE40C292C, 100, 100, "after_clear");

    // Reset asserted while emitting digest byte index 2.
    msg_q = '{8'h61};
    send_all("rst_mid");
    wait_out("rst_mid");
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b1;
      #1;
      chk("rst_mid byte", 32'(out_byte), 32'(exp_byte(32'hE40C292C, k)));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("rst_mid idx2_byte", 32'(out_byte), 32'h29);
    rst_n = 1'b0;
    #1;
    chk("rst_mid out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid out_byte", 32'(out_byte), 32'd0);
    chk("rst_mid busy", 32'(busy), 32'd0);
    chk("rst_mid in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    msg_q = '{8'h61};
    run_msg(32'hE40C292C, 100, 100, "after_rst");

    // Back-to-back messages with random gaps on both sides.
    msg_q = '{8'h61};
    run_msg(32'hE40C292C, 60, 50, "b2b_a");
    set_foobar();
    run_msg(32'hBF9CF968, 60, 50, "b2b_foobar");

    // Random messages against the reference model.
    for (int m = 0; m < 4; m++) begin
      int len;
      len = $urandom_range(12, 1);
      msg_q.delete();
      for (int j = 0; j < len; j++) msg_q.push_back(8'($urandom_range(255)));
      run_msg(fnv_ref(), 70, 60, "random_msg");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fnv_byte_feeder.md
FNV_BYTE_FEEDER -- requirements
Module: fnv_byte_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the input byte buffer depth (power of two, at least 2).
REQ-002 SHALL have parameter OFFSET_BASIS, default 32'd2166136261, meaning the FNV-1a initial hash.
REQ-003 SHALL have parameter FNV_PRIME, default 32'd16777619, meaning the FNV-1a multiplier.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush; aborts any message.
REQ-007 SHALL have port in_data, input, 8 bits: message octet.
REQ-008 SHALL have port in_last, input, 1 bit: in_data is the final octet of the message.
REQ-009 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-010 SHALL have port in_ready, output, 1 bit: octet accepted when in_valid && in_ready.
REQ-011 SHALL have port out_byte, output, 8 bits: digest octet, most significant byte first.
REQ-012 SHALL have port out_valid, output, 1 bit: out_byte is valid.
REQ-013 SHALL have port out_ready, input, 1 bit: octet consumed when out_valid && out_ready.
REQ-014 SHALL have port busy, output, 1 bit: high whenever state is not IDLE or the FIFO is non-empty.

Function
REQ-015 SHALL implement the states IDLE, ABSORB and EMIT, held in a registered hash (32 b), FIFO of {last, data} (9 b entries), byte index (2 b) and a last_seen flag.
REQ-016 SHALL drive in_ready = !fifo_full && !last_seen && state != EMIT, with no combinational path from in_valid.
REQ-017 SHALL push each accepted octet into the FIFO and set last_seen when in_last is accepted.
REQ-018 SHALL move IDLE -> ABSORB on the first cycle the FIFO is non-empty.
REQ-019 SHALL, in ABSORB, pop one entry per cycle while the FIFO is non-empty and update hash <= (hash ^ {24'h0, data}) * FNV_PRIME, mod 2^32.
REQ-020 SHALL stall in ABSORB, with hash held, while the FIFO is empty.
REQ-021 SHALL, when the popped entry has last=1, move ABSORB -> EMIT with index = 0.
REQ-022 SHALL give latency: an octet accepted at edge N is hashed no earlier than edge N+1; out_valid is asserted the cycle after the last octet is hashed.
REQ-023 SHALL, in EMIT, hold out_valid = 1 and out_byte = hash[31-8*index -: 8], stable until the handshake completes.
REQ-024 SHALL increment index on each out handshake; the handshake at index 3 returns the block to IDLE, restores hash to OFFSET_BASIS and clears last_seen.
REQ-025 SHALL allow a push and a pop in the same cycle; the FIFO count stays unchanged and a full FIFO may still pop.
REQ-026 SHALL let the FIFO pointers wrap modulo FIFO_DEPTH, with full and empty distinguished by an explicit count.
REQ-027 SHALL give clear priority over every other event in the same cycle: FIFO emptied, hash = OFFSET_BASIS, state = IDLE, index = 0, last_seen = 0, and the octet offered that cycle discarded.
REQ-028 SHALL keep out_valid low outside EMIT; out_byte is don't-care then but driven to 8'h00.

Reset
REQ-029 SHALL, while rst_n = 0, asynchronously force state = IDLE, hash = OFFSET_BASIS, FIFO empty, index = 0 and last_seen = 0.
REQ-030 SHALL drive these outputs during and immediately after reset: in_ready = 1, out_valid = 0, out_byte = 8'h00, busy = 0.
REQ-031 SHALL abandon a partly absorbed or partly emitted digest when reset asserts mid-message; no octets or state survive reset.

Structure
REQ-032 SHALL place the state encoding, the OFFSET_BASIS and FNV_PRIME constants, and the default FIFO_DEPTH in the shared package fnv_pkg.
REQ-033 SHALL instantiate one combinational sub-module, fnv_1a_step, computing (hash ^ octet) * prime; the FIFO stays inline.

Verification
REQ-034 SHALL verify: single octet 8'h61 ("a") with in_last, out_ready = 1 -> out bytes E4, 0C, 29, 2C, then IDLE and busy = 0.
REQ-035 SHALL verify: "foobar" (66 6F 6F 62 61 72) at full rate -> BF, 9C, F9, 68; in_ready drops when the FIFO is full and never accepts a 5th outstanding octet.
REQ-036 SHALL verify: "foobar" with out_ready low for 10 cycles -> out_byte holds BF throughout; in_ready stays 0 until the 4th digest byte is taken.
REQ-037 SHALL verify: clear pulsed after 3 octets of "foobar", then "a" sent -> digest E40C292C.
REQ-038 SHALL verify: rst_n dropped during EMIT at index 2 -> out_valid = 0 immediately; a following "a" yields E40C292C.
REQ-039 SHALL verify: two back-to-back messages "a" then "foobar" with random in_valid/out_ready gaps -> E40C292C then BF9CF968.
